// File: rtl/rr_pop_arbiter_pkg.sv
// Shared definitions for the round-robin pop arbiter: FSM states,
// destination-field layout and the destination decoder.
package rr_pop_arbiter_pkg;

    localparam int unsigned N_IN   = 4;
    // Destination index occupies the DEST_W most significant bits of a word.
    localparam int unsigned DEST_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSE  = 2'd2
    } state_t;

    function automatic logic [3:0] dest_onehot(input logic [DEST_W-1:0] dest);
        return 4'b0001 << dest;
    endfunction

endpackage

// File: rtl/rr_grant4.sv
// Combinational round-robin picker: first requester after 'last', wrapping 3->0.
module rr_grant4 (
    input  logic [3:0] request,
    input  logic [1:0] last,
    output logic [3:0] grant,
    output logic [1:0] grant_idx
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = last;
        found     = 1'b0;
        idx       = last;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && request[idx]) begin
                found      = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_pop_arbiter.sv
// Pops the input FIFO bank round-robin and routes each word to an output
// FIFO by its destination field, with a fixed 2-cycle pop-to-push latency.
module rr_pop_arbiter #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned N_IN   = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              enable,
    input  logic [N_IN-1:0]   empty_in,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic [N_IN-1:0]   almost_full_in,
    output logic [N_IN-1:0]   pop_out,
    output logic [N_IN-1:0]   push_out,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        state_out,
    output logic              idle_out
);

    import rr_pop_arbiter_pkg::*;

    localparam int unsigned DEST_MSB = DATA_W - 1;
    localparam int unsigned DEST_LSB = DATA_W - DEST_W;

    state_t            state, state_nxt;
    logic [1:0]        last;
    logic [N_IN-1:0]   request;
    logic [N_IN-1:0]   grant;
    logic [1:0]        grant_idx;
    logic              any_req, any_af, issue;
    logic              pend_valid;
    logic [1:0]        pend_src;
    logic              out_valid;
    logic [DATA_W-1:0] captured;

    assign request = ~empty_in;
    assign any_req = |request;
    assign any_af  = |almost_full_in;

    rr_grant4 u_grant (
        .request   (request),
        .last      (last),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Stop/pause decisions use this cycle's flags, so a pop is never issued
    // in the cycle that leaves ACTIVE.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            ACTIVE: begin
                if (any_af)                    state_nxt = PAUSE;
                else if (!enable || !any_req)  state_nxt = IDLE;
                else                           issue     = 1'b1;
            end
            PAUSE: begin
                if (!enable)                   state_nxt = IDLE;
                else if (!any_af)              state_nxt = ACTIVE;
            end
            default: begin
                if (enable && any_req && !any_af) state_nxt = ACTIVE;
                else                              state_nxt = IDLE;
            end
        endcase
    end

    assign pop_out = issue ? grant : '0;

    always_comb begin
        case (pend_src)
            2'd0:    captured = data_in0;
            2'd1:    captured = data_in1;
            2'd2:    captured = data_in2;
            default: captured = data_in3;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state      <= IDLE;
            idle_out   <= 1'b1;
            last       <= 2'd3;
            pend_valid <= 1'b0;
            pend_src   <= '0;
            out_valid  <= 1'b0;
            data_out   <= '0;
        end else begin
            state      <= state_nxt;
            idle_out   <= (state_nxt == IDLE);
            pend_valid <= issue;
            out_valid  <= pend_valid;
            if (issue) begin
                last     <= grant_idx;
                pend_src <= grant_idx;
            end
            if (pend_valid) data_out <= captured;
        end
    end

    assign push_out  = out_valid ? dest_onehot(data_out[DEST_MSB:DEST_LSB]) : '0;
    assign state_out = state;

endmodule

// File: tb/tb_rr_pop_arbiter.sv
// Randomized bench for rr_pop_arbiter: queue-based input FIFOs and a
// rule-level reference model with a timestamped push scoreboard.
module tb_rr_pop_arbiter;

    localparam int S_IDLE = 0, S_ACTIVE = 1, S_PAUSE = 2;

    logic       clk = 1'b0;
    logic       reset_L, enable;
    logic [3:0] empty_in, almost_full_in;
    logic [5:0] data_in0, data_in1, data_in2, data_in3;
    logic [3:0] pop_out, push_out;
    logic [5:0] data_out;
    logic [1:0] state_out;
    logic       idle_out;

    rr_pop_arbiter #(.DATA_W(6), .N_IN(4)) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .enable         (enable),
        .empty_in       (empty_in),
        .data_in0       (data_in0),
        .data_in1       (data_in1),
        .data_in2       (data_in2),
        .data_in3       (data_in3),
        .almost_full_in (almost_full_in),
        .pop_out        (pop_out),
        .push_out       (push_out),
        .data_out       (data_out),
        .state_out      (state_out),
        .idle_out       (idle_out)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0, checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // input FIFO bank
    logic [5:0]  mem [4][64];
    int unsigned hd [4];
    int unsigned tl [4];
    logic [5:0]  rdata [4];

    // reference model
    int          ms, ms_nxt;
    int unsigned mlast, mlast_nxt;
    logic [5:0]  mdata;
    int          exp_t [$];
    logic [5:0]  exp_w [$];
    logic [3:0]  pop_log [$];
    logic [3:0]  push_log [$];
    logic [3:0]  dut_pop_prev;
    logic [3:0]  en_af;
    bit          skip_commit;
    bit          en_v;
    logic [3:0]  af_v;
    int          cyc = 0;

    task automatic put(input int unsigned f, input logic [5:0] w);
        mem[f][tl[f] % 64] = w;
        tl[f]++;
    endtask

    task automatic model_reset();
        ms = S_IDLE; ms_nxt = S_IDLE;
        mlast = 3; mlast_nxt = 3;
        mdata = '0;
        exp_t.delete(); exp_w.delete();
        skip_commit = 1'b1;
    endtask

    task automatic rst_checks();
        check("rst_pop", pop_out, 0);
        check("rst_push", push_out, 0);
        check("rst_data", data_out, 0);
        check("rst_state", state_out, 0);
        check("rst_idle", idle_out, 1);
    endtask

    // Called at negedge+1: assert reset between edges and expect immediate effect.
    task automatic rst_mid();
        #2 reset_L = 1'b0;
        #1 rst_checks();
        model_reset();
        dut_pop_prev = pop_out;
    endtask

    task automatic step();
        logic [3:0]  req, mpop, epush;
        int unsigned g;
        bit          found;
        @(negedge clk);
        cyc++;
        for (int f = 0; f < 4; f++)
            if (dut_pop_prev[f]) begin
                rdata[f] = mem[f][hd[f] % 64];
                hd[f]++;
            end
        if (!skip_commit) begin
            ms = ms_nxt;
            mlast = mlast_nxt;
        end
        skip_commit    = 1'b0;
        reset_L        = 1'b1;
        enable         = en_v;
        almost_full_in = af_v;
        for (int f = 0; f < 4; f++) empty_in[f] = (hd[f] == tl[f]);
        data_in0 = rdata[0]; data_in1 = rdata[1];
        data_in2 = rdata[2]; data_in3 = rdata[3];
        #1;
        req = ~empty_in;
        mpop = '0; ms_nxt = ms; mlast_nxt = mlast; found = 1'b0;
        if (ms == S_ACTIVE) begin
            if (af_v != 0) ms_nxt = S_PAUSE;
            else if (!en_v || req == 0) ms_nxt = S_IDLE;
            else
                for (int unsigned k = 1; k <= 4; k++) begin
                    g = (mlast + k) % 4;
                    if (!found && req[g]) begin
                        found = 1'b1;
                        mpop[g] = 1'b1;
                        mlast_nxt = g;
                        exp_t.push_back(cyc + 2);
                        exp_w.push_back(mem[g][hd[g] % 64]);
                    end
                end
        end else if (ms == S_PAUSE) begin
            if (!en_v) ms_nxt = S_IDLE;
            else if (af_v == 0) ms_nxt = S_ACTIVE;
        end else if (en_v && req != 0 && af_v == 0) begin
            ms_nxt = S_ACTIVE;
        end
        epush = '0;
        if (exp_t.size() > 0 && exp_t[0] == cyc) begin
            mdata = exp_w[0];
            epush = 4'b0001 << mdata[5:4];
            void'(exp_t.pop_front());
            void'(exp_w.pop_front());
        end
        check("pop", pop_out, mpop);
        check("push", push_out, epush);
        check("data", data_out, mdata);
        check("state", state_out, ms);
        check("idle", idle_out, ms == S_IDLE);
        if (pop_out != 0) pop_log.push_back(pop_out);
        if (push_out != 0) push_log.push_back(push_out);
        dut_pop_prev = pop_out;
    endtask

    initial begin
        logic [3:0] fair_exp [8];
        logic [3:0] dest_exp [4];
        fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        dest_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int f = 0; f < 4; f++) begin
            hd[f] = 0; tl[f] = 0; rdata[f] = '0;
        end
        reset_L = 1'b1; enable = 1'b0; empty_in = 4'b1111; almost_full_in = '0;
        data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
        en_v = 1'b1; af_v = '0; dut_pop_prev = '0;
        #1 reset_L = 1'b0;
        #2 rst_checks();
        model_reset();

        // all inputs empty after release: must stay idle
        repeat (5) step();

        // single input, destination 2
        for (int i = 0; i < 3; i++) put(0, 6'b100101);
        repeat (8) step();

        // fairness from reset pointer
        rst_mid();
        pop_log.delete();
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 2; i++) put(f, 6'($urandom));
        repeat (14) step();
        check("fair_len", pop_log.size(), 8);
        for (int i = 0; i < 8 && i < pop_log.size(); i++) check("fair_seq", pop_log[i], fair_exp[i]);

        // destination sweep through one FIFO
        push_log.delete();
        for (int d = 0; d < 4; d++) put(2, {2'(d), 4'($urandom)});
        repeat (10) step();
        check("dest_len", push_log.size(), 4);
        for (int i = 0; i < 4 && i < push_log.size(); i++) check("dest_seq", push_log[i], dest_exp[i]);

        // backpressure during streaming
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 4; i++) put(f, 6'($urandom));
        repeat (4) step();
        af_v = 4'b0010;
        step();
        step();
        check("bp_state", state_out, 2);
        repeat (2) step();
        af_v = '0;
        repeat (12) step();

        // reset with words in flight
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 3; i++) put(f, 6'($urandom));
        repeat (4) step();
        rst_mid();
        repeat (6) step();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int unsigned f = 0; f < 4; f++)
                if (tl[f] - hd[f] < 8 && $urandom_range(0, 3) == 0) put(f, 6'($urandom));
            en_v = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) == 0) af_v = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 3) == 0) af_v = '0;
            if ($urandom_range(0, 199) == 0) rst_mid();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_pop_arbiter.md
Name: rr_pop_arbiter

Overview:
- Downstream consumer of the four class FIFOs (fifo_cond instances).
- Round-robin pops one input FIFO per cycle.
- Routes each popped word to one of four output FIFOs by its destination field, and stalls on downstream almost-full.
- Sits between the input FIFO bank and the output FIFO bank of the switch datapath.

Parameters:
- DATA_W, 6, word width; the two MSBs [DATA_W-1:DATA_W-2] are the destination index.
- N_IN, 4, number of input FIFOs (fixed at 4 in this revision).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, no new pops are issued; an in-flight word still completes.
- empty_in  in  4  empty flags of input FIFOs 0..3.
- data_in0..data_in3  in  DATA_W each  read data of input FIFOs 0..3.
- almost_full_in  in  4  almost_full flags of output FIFOs 0..3.
- pop_out  out  4  one-hot pop to input FIFOs.
- push_out  out  4  one-hot push to output FIFOs.
- data_out  out  DATA_W  word to output FIFOs.
- state_out  out  2  current FSM state.
- idle_out  out  1  high in IDLE.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - pop_out=0, push_out=0, data_out=0, state_out=IDLE, idle_out=1.
  - RR pointer last=3, so FIFO 0 has first priority.
  - pending flag cleared; an in-flight word is dropped and never pushed.
- Read timing contract: pop_out[i] asserted in cycle N means data_in<i> holds the word in cycle N+1.
  - The block captures that word at the end of N+1.
  - It drives push_out/data_out as registered outputs in cycle N+2.
  - Total pop-to-push latency is 2 cycles.
  - Throughput is 1 word/cycle in steady state.
- Pipeline regs:
  - pend_valid / pend_src (2b) at stage N+1.
  - out_valid / data_out at stage N+2.
- FSM states (2b encoding): IDLE=0, ACTIVE=1, PAUSE=2; 3 is unused and decodes to IDLE.
  - IDLE: no pops. Go to ACTIVE when enable=1, empty_in!=4'b1111 and almost_full_in==0.
  - ACTIVE: each cycle, grant = first i in order last+1, last+2, ... (mod 4) with empty_in[i]=0.
    - Assert pop_out[grant] and set last<=grant.
    - Go to PAUSE if any almost_full_in bit is 1.
    - Go to IDLE if enable=0 or all inputs are empty.
    - The pause/idle check is combinational in the same cycle; no pop is issued in the transition cycle.
  - PAUSE: no pops. Return to ACTIVE when almost_full_in==0 and enable=1; return to IDLE if enable=0.
- Grant invariants:
  - pop_out is always one-hot or zero.
  - pop_out is never asserted to a FIFO whose empty_in is 1 in that cycle.
- Backpressure margin: at most 2 words are in flight after almost_full rises (stages N+1 and N+2). Both are always pushed. Output FIFOs set their buffer_full threshold with ≥2 entries of slack.
- Routing:
  - push_out = one-hot of data_out[DATA_W-1:DATA_W-2], asserted only when out_valid=1.
  - The word is pushed unmodified.
- Simultaneous events:
  - enable falling while a pop is in flight: the word completes.
  - All inputs going empty in the same cycle as a grant: the grant still uses that cycle's flags.
- RR pointer wraps 3→0.
- Starvation bound: with continuous traffic, any non-empty input is served within 4 grants.

Decomposition:
- Shared package / `define header:
  - state encodings IDLE/ACTIVE/PAUSE;
  - DEST_MSB/DEST_LSB field positions;
  - N_IN.
- Sub-module rr_grant4: combinational round-robin priority picker.
  - Inputs: request[3:0] (=~empty_in) and last[1:0].
  - Outputs: one-hot grant[3:0] and grant_idx[1:0].
- The FSM, pipeline registers and routing decoder stay in rr_pop_arbiter.

Test Plan:
- Reset checks:
  - Assert reset_L=0 mid-stream with a word in flight → outputs zero immediately (asynchronously); after release no push of the dropped word; state_out=0, idle_out=1.
  - Release reset with empty_in=4'b1111 → stays IDLE, pop_out=0 indefinitely.
- Single input: empty_in=4'b1110, data_in0=6'b10_0101, held 3 words → pop_out=0001 for 3 cycles; push_out=0100 with data_out=6'b100101 two cycles after each pop.
- Fairness: all four FIFOs non-empty, each with 2 words → pop_out sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000; then IDLE.
- Backpressure: almost_full_in=4'b0010 asserted during streaming → state_out=2 next cycle; no further pops; the ≤2 in-flight words are still pushed. Deassert → ACTIVE; the next grant resumes after the last-served FIFO.
- Destination sweep: one FIFO holds words with MSBs 00, 01, 10, 11 → push_out 0001, 0010, 0100, 1000 in order, with unmodified data.
